// File: rtl/difeq_scheduler.sv
//==============================================================================
// Module      : difeq_scheduler
// Description : Round-robin scheduler that shares a single difference-equation
//               datapath across N_CH channels:
//               y[n] = x[n] - x[n-1] + x[n-2] + x[n-3] + (y[n-1]>>>1) + (y[n-2]>>>2)
//               Optional per-channel history clear: define DIFEQ_CLEAR_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module difeq_scheduler #(
    parameter int N_BITS = 8,
    parameter int N_CH   = 4
) (
    input  logic                                   clock,
    input  logic                                   i_reset,
    input  logic [N_CH-1:0]                        i_valid,
    input  logic [N_CH*N_BITS-1:0]                 i_x,
`ifdef DIFEQ_CLEAR_EN
    input  logic [N_CH-1:0]                        i_clear,
`endif
    output logic [N_CH-1:0]                        o_ready,
    output logic [N_BITS+2:0]                      o_y,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] o_ch,
    output logic                                   o_valid
);

    localparam int c_YW   = N_BITS + 3;
    localparam int c_CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_CH_W-1:0]   r_last;
    logic [c_CH_W-1:0]   r_ch;
    logic [c_CH_W-1:0]   r_och;
    logic [N_BITS-1:0]   r_x_cap;
    logic [c_YW-1:0]     r_y;

    logic [N_BITS-1:0]   r_x1 [N_CH];
    logic [N_BITS-1:0]   r_x2 [N_CH];
    logic [N_BITS-1:0]   r_x3 [N_CH];
    logic [c_YW-1:0]     r_y1 [N_CH];
    logic [c_YW-1:0]     r_y2 [N_CH];

    logic [N_BITS-1:0]   w_x_arr [N_CH];
    logic [c_CH_W-1:0]   w_sel;
    logic                w_any;
    logic [N_CH-1:0]     w_grant;

    logic signed [c_YW-1:0] w_xs0;
    logic signed [c_YW-1:0] w_xs1;
    logic signed [c_YW-1:0] w_xs2;
    logic signed [c_YW-1:0] w_xs3;
    logic signed [c_YW-1:0] w_y1;
    logic signed [c_YW-1:0] w_y2;
    logic signed [c_YW-1:0] w_y_calc;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            w_x_arr[k] = i_x[k*N_BITS +: N_BITS];
        end
    end

    // Lowest valid index above r_last wins; otherwise wrap to lowest valid index.
    always_comb begin
        w_sel = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (i_valid[k] && (k <= int'(r_last))) w_sel = c_CH_W'(k);
        end
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (i_valid[k] && (k > int'(r_last))) w_sel = c_CH_W'(k);
        end
    end

    assign w_any   = |i_valid;
    assign w_grant = w_any ? (N_CH'(1) << w_sel) : '0;
    assign o_ready = ((r_state == S_IDLE) && !i_reset) ? w_grant : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_CALC;
            S_CALC:  w_state_nxt = S_OUT;
            S_OUT:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_xs0 = {{3{r_x_cap[N_BITS-1]}}, r_x_cap};
    assign w_xs1 = {{3{r_x1[r_ch][N_BITS-1]}}, r_x1[r_ch]};
    assign w_xs2 = {{3{r_x2[r_ch][N_BITS-1]}}, r_x2[r_ch]};
    assign w_xs3 = {{3{r_x3[r_ch][N_BITS-1]}}, r_x3[r_ch]};
    assign w_y1  = r_y1[r_ch];
    assign w_y2  = r_y2[r_ch];

    assign w_y_calc = w_xs0 - w_xs1 + w_xs2 + w_xs3 + (w_y1 >>> 1) + (w_y2 >>> 2);

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_last  <= c_CH_W'(N_CH - 1);
            r_ch    <= '0;
            r_och   <= '0;
            r_x_cap <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ch    <= w_sel;
                        r_last  <= w_sel;
                        r_x_cap <= w_x_arr[w_sel];
                    end
                end
                S_CALC: begin
                    r_y   <= w_y_calc;
                    r_och <= r_ch;
                end
                default: ;
            endcase
        end
    end

    // Clear is applied after the shift so it overrides a same-cycle history write.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            for (int k = 0; k < N_CH; k++) begin
                r_x1[k] <= '0;
                r_x2[k] <= '0;
                r_x3[k] <= '0;
                r_y1[k] <= '0;
                r_y2[k] <= '0;
            end
        end else begin
            if (r_state == S_OUT) begin
                r_x1[r_ch] <= r_x_cap;
                r_x2[r_ch] <= r_x1[r_ch];
                r_x3[r_ch] <= r_x2[r_ch];
                r_y1[r_ch] <= r_y;
                r_y2[r_ch] <= r_y1[r_ch];
            end
`ifdef DIFEQ_CLEAR_EN
            for (int k = 0; k < N_CH; k++) begin
                if (i_clear[k]) begin
                    r_x1[k] <= '0;
                    r_x2[k] <= '0;
                    r_x3[k] <= '0;
                    r_y1[k] <= '0;
                    r_y2[k] <= '0;
                end
            end
`endif
        end
    end

    assign o_y     = r_y;
    assign o_ch    = r_och;
    assign o_valid = (r_state == S_OUT) && !i_reset;

endmodule

`default_nettype wire

// File: tb/tb_difeq_scheduler.sv
//==============================================================================
// Module      : tb_difeq_scheduler
// Description : Scoreboard bench for difeq_scheduler (N_BITS=8, N_CH=4).
//               Clear scenario included when DIFEQ_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_difeq_scheduler;

    localparam int NB = 8;
    localparam int NC = 4;
    localparam int YW = NB + 3;

    typedef struct {
        int             ch;
        logic [YW-1:0]  y;
        int             cyc;
    } exp_t;

    logic              clock;
    logic              i_reset;
    logic [NC-1:0]     i_valid;
    logic [NC*NB-1:0]  i_x;
`ifdef DIFEQ_CLEAR_EN
    logic [NC-1:0]     i_clear;
`endif
    logic [NC-1:0]     o_ready;
    logic [YW-1:0]     o_y;
    logic [1:0]        o_ch;
    logic              o_valid;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    difeq_scheduler #(.N_BITS(NB), .N_CH(NC)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_x     (i_x),
`ifdef DIFEQ_CLEAR_EN
        .i_clear (i_clear),
`endif
        .o_ready (o_ready),
        .o_y     (o_y),
        .o_ch    (o_ch),
        .o_valid (o_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every o_valid pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (o_valid === 1'b1) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: o_valid with ch=%0d y=%h at cyc %0d, none required", o_ch, o_y, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (int'(o_ch) != e.ch || o_y !== e.y || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL out_ch%0d: got ch=%0d y=%h cyc=%0d, required ch=%0d y=%h cyc=%0d",
                             e.ch, o_ch, o_y, cyc, e.ch, e.y, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        i_reset = 1'b1;
        i_valid = '1;
        #1;
        check("ready_in_reset", 32'(o_ready), 32'h0);
        @(posedge clock); #1;
        i_reset = 1'b0;
        i_valid = '0;
        check("reset_o_valid", 32'(o_valid), 32'h0);
        check("reset_o_y", 32'(o_y), 32'h0);
        check("reset_o_ch", 32'(o_ch), 32'h0);
    endtask

    // Present vmask/xvec until a grant appears, check the granted channel, and
    // queue the expected result (unless the transaction is aborted by reset).
    task automatic send(input logic [NC-1:0] vmask, input logic [NC*NB-1:0] xvec,
                        input int exp_ch, input logic [YW-1:0] ey, input bit abort,
                        output int tries);
        bit got;
        @(posedge clock); #1;
        i_valid = vmask;
        i_x     = xvec;
        tries   = 0;
        got     = 1'b0;
        while (!got && tries < 20) begin
            #1;
            if (o_ready != '0) got = 1'b1;
            else begin
                @(posedge clock); #1;
                tries++;
            end
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL grant_timeout: o_ready=%b, required grant to ch%0d", o_ready, exp_ch);
        end else if (o_ready !== (NC'(1) << exp_ch)) begin
            n_fail++;
            $display("FAIL grant_ch: o_ready=%b, required %b", o_ready, NC'(1) << exp_ch);
        end else if (!abort) begin
            q.push_back('{exp_ch, ey, cyc + 2});
        end
        @(posedge clock); #1;
        i_valid = '0;
        if (abort) begin
            i_reset = 1'b1;
            @(posedge clock); #1;
            i_reset = 1'b0;
        end
        repeat (3) @(posedge clock);
    endtask

    task automatic send1(input int ch, input logic [NB-1:0] x, input logic [YW-1:0] ey,
                         input bit abort);
        logic [NC*NB-1:0] xv;
        logic [NC-1:0]    vm;
        int               t;
        xv = '0;
        xv[ch*NB +: NB] = x;
        vm = '0;
        vm[ch] = 1'b1;
        send(vm, xv, ch, ey, abort, t);
    endtask

    initial begin
        int          tries;
        int          grants;
        int          last_g;
        int          exp_ch;
        bit          quiet;
        logic [YW-1:0] rr_y [8];

        i_reset = 1'b1;
        i_valid = '0;
        i_x     = '0;
`ifdef DIFEQ_CLEAR_EN
        i_clear = '0;
`endif
        repeat (2) @(posedge clock);

        // Repeated x=10 on ch0: 10, 5, 14.
        do_reset();
        send1(0, 8'd10, 11'd10, 1'b0);
        send1(0, 8'd10, 11'd5,  1'b0);
        send1(0, 8'd10, 11'd14, 1'b0);

        // Most negative input, then an independent channel.
        do_reset();
        send1(1, 8'h80, 11'h780, 1'b0);
        send1(2, 8'd20, 11'd20,  1'b0);
        send1(2, 8'd20, 11'd10,  1'b0);
        #1;
        check("hold_o_y", 32'(o_y), 32'h00A);
        check("hold_o_ch", 32'(o_ch), 32'h2);
        check("hold_o_valid", 32'(o_valid), 32'h0);

        // Round robin with all channels requesting continuously.
        do_reset();
        rr_y = '{11'd1, 11'd2, 11'd3, 11'd4, 11'd0, 11'd1, 11'd1, 11'd2};
        @(posedge clock); #1;
        i_x     = {8'd4, 8'd3, 8'd2, 8'd1};
        i_valid = '1;
        grants  = 0;
        last_g  = 0;
        for (int c = 0; c < 40 && grants < 8; c++) begin
            #1;
            if (o_ready != '0) begin
                exp_ch = grants % NC;
                check("rr_grant", 32'(o_ready), 32'(NC'(1) << exp_ch));
                if (grants > 0) check("rr_spacing", 32'(cyc - last_g), 32'd3);
                q.push_back('{exp_ch, rr_y[grants], cyc + 2});
                last_g = cyc;
                grants++;
            end
            @(posedge clock); #1;
        end
        i_valid = '0;
        check("rr_grant_count", 32'(grants), 32'd8);
        repeat (3) @(posedge clock);

        // Pointer after a ch0 grant: lone ch3 wins at once, then ch0 beats ch3.
        do_reset();
        send1(0, 8'd0, 11'd0, 1'b0);
        send(4'b1000, {8'd7, 24'd0}, 3, 11'd7, 1'b0, tries);
        check("ch3_first_idle", 32'(tries), 32'd0);
        send(4'b1001, {8'd9, 16'd0, 8'd5}, 0, 11'd5, 1'b0, tries);

        // Reset during CALC aborts the transaction and leaves history untouched.
        do_reset();
        send1(0, 8'd10, 11'd0, 1'b1);
        check("abort_no_pending", 32'(q.size()), 32'd0);
        send1(0, 8'd10, 11'd10, 1'b0);

`ifdef DIFEQ_CLEAR_EN
        do_reset();
        send1(0, 8'd10, 11'd10, 1'b0);
        send1(0, 8'd10, 11'd5,  1'b0);
        @(posedge clock); #1;
        i_clear = 4'b0001;
        @(posedge clock); #1;
        i_clear = '0;
        send1(0, 8'd10, 11'd10, 1'b0);
`endif

        quiet = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) @(posedge clock);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (o_valid !== 1'b0) quiet = 1'b0;
        end
        check("idle_quiet", 32'(quiet), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/difeq_scheduler.md
DIFEQ_SCHEDULER -- requirements
Module: difeq_scheduler

Interface
REQ-001 SHALL have parameter N_BITS, default 8: sample width of each channel's input x.
REQ-002 SHALL have parameter N_CH, default 4: number of independent channels that share one difference-equation datapath (2..16).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_valid, input, N_CH bits: bit k high means channel k presents a sample.
REQ-006 SHALL have port i_x, input, N_CH*N_BITS bits: channel k sample in bits [k*N_BITS +: N_BITS], two's complement.
REQ-007 SHALL have port o_ready, output, N_CH bits: one-hot; bit k high means channel k's sample is accepted this cycle.
REQ-008 SHALL have port o_y, output, N_BITS+3 bits: computed output, two's complement.
REQ-009 SHALL have port o_ch, output, clog2(N_CH) bits (minimum 1): channel index of o_y.
REQ-010 SHALL have port o_valid, output, 1 bit: o_y and o_ch are valid for exactly this cycle.
REQ-011 SHALL have port i_clear, input, N_CH bits, present only when DIFEQ_CLEAR_EN is defined.

Function
REQ-012 SHALL compute per channel y[n] = x[n] - x[n-1] + x[n-2] + x[n-3] + (y[n-1] >>> 1) + (y[n-2] >>> 2), with arithmetic shifts.
REQ-013 SHALL keep per channel x[n-1..n-3] (N_BITS each) and y[n-1..n-2] (N_BITS+3 each) in a register bank; the adder datapath is single and shared.
REQ-014 SHALL sign-extend x to N_BITS+3 bits and wrap the result modulo 2^(N_BITS+3); no saturation.
REQ-015 SHALL use FSM states IDLE, CALC, OUT; IDLE->CALC when any i_valid bit is high, CALC->OUT unconditionally, OUT->IDLE unconditionally.
REQ-016 SHALL, in IDLE with any i_valid high, select one channel by round-robin starting from last-granted+1, drive o_ready for that channel combinationally in the same cycle, and capture its i_x.
REQ-017 SHALL keep o_ready all-zero in CALC and OUT, and in IDLE when i_valid is all-zero.
REQ-018 SHALL, in CALC, register the result of REQ-012 using the captured x and the selected channel's history.
REQ-019 SHALL, in OUT, assert o_valid with o_y and o_ch, and shift the channel's history (x[n-1]<=x[n], y[n-1]<=y[n], etc.).
REQ-020 SHALL give a latency from the accept cycle to o_valid of 2 cycles; peak throughput is one sample per 3 cycles.
REQ-021 SHALL leave the history of non-selected channels unchanged.
REQ-022 SHALL hold o_y and o_ch at their last values when o_valid is low.

Reset
REQ-023 SHALL, while i_reset is high at a clock edge, set FSM to IDLE, all histories to 0, o_y to 0, o_ch to 0, o_valid to 0, and the round-robin pointer so that channel 0 has highest priority next.
REQ-024 SHALL drive o_ready to 0 during any cycle in which i_reset is high.
REQ-025 SHALL, on reset mid-operation (CALC or OUT), abort with no o_valid pulse and no history update.

Configuration
REQ-026 SHALL, with DIFEQ_CLEAR_EN defined, zero all history of channel k at a clock edge when i_clear[k] is high; clear wins over a simultaneous OUT history write to the same channel; an in-flight result is still output.
REQ-027 SHALL, without DIFEQ_CLEAR_EN, omit the i_clear port and its logic; history is cleared only by i_reset.

Verification
REQ-028 Reset, then ch0 sends x=10 three times, idle between -> o_y=10, 5, 14 with o_ch=0, each o_valid 2 cycles after the accept.
REQ-029 All 4 i_valid held high, N_BITS=8 -> o_ready grants 0,1,2,3,0,... one every 3 cycles, never two bits at once.
REQ-030 Ch1 sends x=-128 once, ch2 sends x=20 once -> ch1 o_y=-128 (0x780 in 11 bits), ch2 o_y=20; ch2 history unaffected by ch1.
REQ-031 Reset asserted in the CALC cycle -> no o_valid; next ch0 x=10 yields o_y=10.
REQ-032 DIFEQ_CLEAR_EN defined: ch0 x=10, x=10 (o_y=10, 5), pulse i_clear[0], then x=10 -> o_y=10.
REQ-033 Only ch3 valid after grants to ch0 -> ch3 granted on the first IDLE cycle; pointer then makes ch0 the highest priority.
